// File: rtl/ahblite_pkg.sv
// Shared AHB-Lite definitions: transfer/size/response codes, responder FSM
// states, and the byte-lane helpers used by the SRAM responder.
package ahblite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_t;

    // Byte lanes touched by a transfer of the given size at addr[1:0].
    function automatic logic [3:0] byte_enable(input logic [2:0] size, input logic [1:0] addr);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            HSIZE_BYTE: be = 4'b0001 << addr;
            HSIZE_HALF: be = addr[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: be = 4'b1111;
            default:    be = 4'b0000;
        endcase
        return be;
    endfunction

    // Overlay the enabled lanes of new_word on old_word.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        logic [31:0] w;
        w = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) w[8*i +: 8] = new_word[8*i +: 8];
        end
        return w;
    endfunction

endpackage

// File: rtl/ahblite_dpram.sv
// Word SRAM: port A has an independent byte-lane write and a registered read
// (read-first on a same-word collision); port B is a registered read-only port.
module ahblite_dpram #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_re,
    input  logic [ADDR_WIDTH-1:0] a_raddr,
    output logic [31:0]           a_rdata,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_waddr,
    input  logic [3:0]            a_be,
    input  logic [31:0]           a_wdata,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    output logic [31:0]           b_rdata
);

    logic [31:0] mem [0:(1<<ADDR_WIDTH)-1];

    // Byte-lane write; array contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (a_we) begin
            for (int i = 0; i < 4; i++) begin
                if (a_be[i]) mem[a_waddr][8*i +: 8] <= a_wdata[8*i +: 8];
            end
        end
    end

    // Read registers: port A holds its value until the next enabled read,
    // port B samples every cycle. Both see the pre-write word on a collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_rdata <= '0;
            b_rdata <= '0;
        end else begin
            if (a_re) a_rdata <= mem[a_raddr];
            b_rdata <= mem[b_addr];
        end
    end

endmodule

// File: rtl/ahblite_wait_sram.sv
// AHB-Lite responder over a dual-port SRAM with programmable wait states,
// two-cycle ERROR response, write-to-read forwarding and a video read port.
// Handshake: a transfer is accepted when HSEL & HREADY & HTRANS[1] are high on
// a rising edge; its data phase completes on the first edge with HREADYOUT high.
module ahblite_wait_sram
    import ahblite_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic [2:0]            HSIZE,
    input  logic                  HWRITE,
    input  logic [31:0]           HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [31:0]           HRDATA,
    input  logic [ADDR_WIDTH-1:0] VID_ADDR,
    output logic [31:0]           VID_RDATA,
    output state_t                dbg_state
);

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

    state_t                state, state_next;
    logic [3:0]            cnt, cnt_next;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [3:0]            be_q;
    logic                  write_q;
    logic                  fwd_q;
    logic [3:0]            fwd_be_q;
    logic [31:0]           fwd_data_q;
    logic [31:0]           ram_rdata;

    logic                  accept, addr_err, wr_now, rd_take, fwd;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic                  unused_bits;

    assign unused_bits = ^{HADDR[31:ADDR_WIDTH+2], HTRANS[0]};

    assign accept    = HSEL & HREADY & HTRANS[1];
    assign word_addr = HADDR[ADDR_WIDTH+1:2];
    assign addr_err  = (HSIZE > HSIZE_WORD)
                     | ((HSIZE == HSIZE_HALF) & HADDR[0])
                     | ((HSIZE == HSIZE_WORD) & (HADDR[1:0] != 2'b00));
    assign wr_now    = (state == ST_DATA) & write_q;
    assign rd_take   = accept & ~HWRITE & ~addr_err;
    assign fwd       = rd_take & wr_now & (word_addr == addr_q);
    assign dbg_state = state;

    // State and wait-counter registers.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next state and per-state HREADYOUT/HRESP.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        HREADYOUT  = 1'b1;
        HRESP      = HRESP_OKAY;
        case (state)
            ST_WAIT: begin
                HREADYOUT = 1'b0;
                if (cnt <= 4'd1) begin
                    state_next = ST_DATA;
                    cnt_next   = 4'd0;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            ST_ERR1: begin
                HREADYOUT  = 1'b0;
                HRESP      = HRESP_ERROR;
                state_next = ST_ERR2;
            end
            default: begin
                // IDLE, DATA and ERR2 can all take a new address phase.
                if (state == ST_ERR2) HRESP = HRESP_ERROR;
                state_next = ST_IDLE;
                if (accept) begin
                    if (addr_err) begin
                        state_next = ST_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_next = ST_WAIT;
                        cnt_next   = WAIT_LOAD;
                    end else begin
                        state_next = ST_DATA;
                    end
                end
            end
        endcase
    end

    // Address-phase capture; errored transfers are flagged as non-writes.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            addr_q  <= '0;
            be_q    <= 4'b0000;
            write_q <= 1'b0;
        end else if (accept) begin
            addr_q  <= word_addr;
            be_q    <= byte_enable(HSIZE, HADDR[1:0]);
            write_q <= HWRITE & ~addr_err;
        end
    end

    // Forwarding record for a read that collides with the completing write.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            fwd_q      <= 1'b0;
            fwd_be_q   <= 4'b0000;
            fwd_data_q <= '0;
        end else if (rd_take) begin
            fwd_q      <= fwd;
            fwd_be_q   <= be_q;
            fwd_data_q <= HWDATA;
        end
    end

    assign HRDATA = merge_bytes(ram_rdata, fwd_data_q, fwd_q ? fwd_be_q : 4'b0000);

    ahblite_dpram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
        .clk     (HCLK),
        .rst     (HRESET),
        .a_re    (rd_take),
        .a_raddr (word_addr),
        .a_rdata (ram_rdata),
        .a_we    (wr_now),
        .a_waddr (addr_q),
        .a_be    (be_q),
        .a_wdata (HWDATA),
        .b_addr  (VID_ADDR),
        .b_rdata (VID_RDATA)
    );

endmodule

// File: tb/tb_ahblite_wait_sram.sv
// Bench for ahblite_wait_sram: one instance with zero wait states (sel=0) and
// one with a single wait state (sel=1) share the driven bus signals.
module tb_ahblite_wait_sram;
    import ahblite_pkg::*;

    logic        clk;
    logic        hreset;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic        hwrite;
    logic [31:0] hwdata;
    logic [9:0]  vid_addr;
    int          sel;

    logic        hsel0, hreadyout0, hresp0;
    logic [31:0] hrdata0, vid_rdata0;
    state_t      dbg0;
    logic        hsel1, hreadyout1, hresp1;
    logic [31:0] hrdata1, vid_rdata1;
    state_t      dbg1;

    logic        hreadyout_m, hresp_m;
    logic [31:0] hrdata_m;

    logic [31:0] ref_mem [0:1][0:1023];
    logic [31:0] exp_q[$];
    int          total;
    int          bad;

    assign hsel0       = hsel && (sel == 0);
    assign hsel1       = hsel && (sel == 1);
    assign hreadyout_m = (sel == 1) ? hreadyout1 : hreadyout0;
    assign hresp_m     = (sel == 1) ? hresp1 : hresp0;
    assign hrdata_m    = (sel == 1) ? hrdata1 : hrdata0;

    ahblite_wait_sram #(.ADDR_WIDTH(10), .WAIT_STATES(0)) dut0 (
        .HCLK(clk), .HRESET(hreset), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans),
        .HSIZE(hsize), .HWRITE(hwrite), .HWDATA(hwdata), .HREADY(hreadyout0),
        .HREADYOUT(hreadyout0), .HRESP(hresp0), .HRDATA(hrdata0),
        .VID_ADDR(vid_addr), .VID_RDATA(vid_rdata0), .dbg_state(dbg0)
    );

    ahblite_wait_sram #(.ADDR_WIDTH(10), .WAIT_STATES(1)) dut1 (
        .HCLK(clk), .HRESET(hreset), .HSEL(hsel1), .HADDR(haddr), .HTRANS(htrans),
        .HSIZE(hsize), .HWRITE(hwrite), .HWDATA(hwdata), .HREADY(hreadyout1),
        .HREADYOUT(hreadyout1), .HRESP(hresp1), .HRDATA(hrdata1),
        .VID_ADDR(vid_addr), .VID_RDATA(vid_rdata1), .dbg_state(dbg1)
    );

    // Clock and watchdog.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Lanes written by a transfer, listed out explicitly.
    function automatic logic [3:0] lanes(input logic [2:0] size, input logic [1:0] a);
        case (size)
            3'd0:    lanes = (a == 2'd0) ? 4'b0001 : (a == 2'd1) ? 4'b0010 :
                             (a == 2'd2) ? 4'b0100 : 4'b1000;
            3'd1:    lanes = (a >= 2'd2) ? 4'b1100 : 4'b0011;
            default: lanes = 4'b1111;
        endcase
    endfunction

    task automatic ref_write(input int s, input logic [31:0] addr, input logic [2:0] size,
                             input logic [31:0] data);
        logic [3:0]  be;
        logic [31:0] w;
        be = lanes(size, addr[1:0]);
        w  = ref_mem[s][addr[11:2]];
        for (int i = 0; i < 4; i++) begin
            if (be[i]) w[8*i +: 8] = data[8*i +: 8];
        end
        ref_mem[s][addr[11:2]] = w;
    endtask

    task automatic drive_idle();
        hsel   = 1'b0;
        htrans = HTRANS_IDLE;
        hwrite = 1'b0;
    endtask

    task automatic drive_addr(input logic wr, input logic [31:0] addr, input logic [2:0] size);
        hsel   = 1'b1;
        htrans = HTRANS_NONSEQ;
        haddr  = addr;
        hsize  = size;
        hwrite = wr;
    endtask

    // One isolated transfer on the selected instance; records HREADYOUT and
    // HRESP for each data-phase cycle (bit 0 = first cycle).
    task automatic do_xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                           input logic [31:0] wdata, output int cycles,
                           output logic [31:0] rdy_tr, output logic [31:0] rsp_tr,
                           output logic [31:0] rdata);
        logic done;
        @(negedge clk);
        drive_addr(wr, addr, size);
        @(negedge clk);
        drive_idle();
        hwdata = wdata;
        cycles = 0;
        rdy_tr = '0;
        rsp_tr = '0;
        rdata  = '0;
        done   = 1'b0;
        while (!done && cycles < 32) begin
            rdy_tr[cycles] = hreadyout_m;
            rsp_tr[cycles] = hresp_m;
            cycles++;
            if (hreadyout_m) begin
                done  = 1'b1;
                rdata = hrdata_m;
            end else begin
                @(negedge clk);
            end
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL xfer_timeout: addr=%h no HREADYOUT within 32 cycles", addr);
        end
    endtask

    task automatic test_reset();
        hreset = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (hreadyout1 !== 1'b1) begin bad++; $display("FAIL reset_hreadyout: got %b want 1", hreadyout1); end
        total++; if (hresp1 !== 1'b0) begin bad++; $display("FAIL reset_hresp: got %b want 0", hresp1); end
        total++; if (hrdata1 !== 32'h0) begin bad++; $display("FAIL reset_hrdata: got %h want 0", hrdata1); end
        total++; if (vid_rdata1 !== 32'h0) begin bad++; $display("FAIL reset_vid_rdata: got %h want 0", vid_rdata1); end
        total++; if (hrdata0 !== 32'h0) begin bad++; $display("FAIL reset_hrdata0: got %h want 0", hrdata0); end
        total++; if (dbg0 !== ST_IDLE) begin bad++; $display("FAIL reset_state: got %0d want %0d", dbg0, ST_IDLE); end
        hreset = 1'b0;
    endtask

    task automatic test_wait_states();
        int          cyc;
        logic [31:0] rdy, rsp, rd, ex;
        sel = 1;
        do_xfer(1'b1, 32'h10, HSIZE_WORD, 32'hDEADBEEF, cyc, rdy, rsp, rd);
        ref_write(1, 32'h10, HSIZE_WORD, 32'hDEADBEEF);
        total++; if (cyc !== 2 || rdy[1:0] !== 2'b10) begin bad++; $display("FAIL ws1_write_len: got cycles=%0d rdy=%b want 2 / 10", cyc, rdy[1:0]); end
        total++; if (rsp[1:0] !== 2'b00) begin bad++; $display("FAIL ws1_write_resp: got %b want 00", rsp[1:0]); end
        exp_q.push_back(ref_mem[1][32'h10 >> 2]);
        do_xfer(1'b0, 32'h10, HSIZE_WORD, 32'h0, cyc, rdy, rsp, rd);
        ex = exp_q.pop_front();
        total++; if (cyc !== 2 || rdy[1:0] !== 2'b10) begin bad++; $display("FAIL ws1_read_len: got cycles=%0d rdy=%b want 2 / 10", cyc, rdy[1:0]); end
        total++; if (rd !== ex || rsp[1:0] !== 2'b00) begin bad++; $display("FAIL ws1_read_data: got %h resp=%b want %h resp=00", rd, rsp[1:0], ex); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ex, rnd, rd, rdy, rsp;
        int          cyc;
        sel = 0;
        rnd = $urandom();
        @(negedge clk);
        drive_addr(1'b1, 32'h20, HSIZE_WORD);
        @(negedge clk);
        total++; if (hreadyout_m !== 1'b1) begin bad++; $display("FAIL b2b_write_ready: got %b want 1", hreadyout_m); end
        hwdata = 32'h11223344;
        ref_write(0, 32'h20, HSIZE_WORD, 32'h11223344);
        drive_addr(1'b0, 32'h20, HSIZE_WORD);
        exp_q.push_back(ref_mem[0][8]);
        @(negedge clk);
        ex = exp_q.pop_front();
        total++; if (hreadyout_m !== 1'b1 || hrdata_m !== ex) begin bad++; $display("FAIL b2b_fwd_read: got rdy=%b data=%h want 1 / %h", hreadyout_m, hrdata_m, ex); end
        drive_addr(1'b1, 32'h24, HSIZE_WORD);
        @(negedge clk);
        hwdata = rnd;
        ref_write(0, 32'h24, HSIZE_WORD, rnd);
        drive_addr(1'b0, 32'h20, HSIZE_WORD);
        exp_q.push_back(ref_mem[0][8]);
        @(negedge clk);
        ex = exp_q.pop_front();
        total++; if (hrdata_m !== ex) begin bad++; $display("FAIL b2b_other_word: got %h want %h", hrdata_m, ex); end
        drive_addr(1'b1, 32'h21, HSIZE_BYTE);
        @(negedge clk);
        hwdata = 32'h0000EE00;
        ref_write(0, 32'h21, HSIZE_BYTE, 32'h0000EE00);
        drive_addr(1'b0, 32'h20, HSIZE_WORD);
        exp_q.push_back(ref_mem[0][8]);
        @(negedge clk);
        ex = exp_q.pop_front();
        total++; if (hrdata_m !== ex) begin bad++; $display("FAIL b2b_fwd_merge: got %h want %h", hrdata_m, ex); end
        drive_idle();
        exp_q.push_back(ref_mem[0][9]);
        do_xfer(1'b0, 32'h24, HSIZE_WORD, 32'h0, cyc, rdy, rsp, rd);
        ex = exp_q.pop_front();
        total++; if (rd !== ex || cyc !== 1) begin bad++; $display("FAIL ws0_read_rand: got %h cycles=%0d want %h / 1", rd, cyc, ex); end
    endtask

    task automatic test_byte_lanes();
        int          cyc;
        logic [31:0] rdy, rsp, rd, ex;
        sel = 1;
        do_xfer(1'b1, 32'h20, HSIZE_WORD, 32'h00000000, cyc, rdy, rsp, rd);
        ref_write(1, 32'h20, HSIZE_WORD, 32'h0);
        do_xfer(1'b1, 32'h23, HSIZE_BYTE, 32'hAA000000, cyc, rdy, rsp, rd);
        ref_write(1, 32'h23, HSIZE_BYTE, 32'hAA000000);
        exp_q.push_back(ref_mem[1][8]);
        do_xfer(1'b0, 32'h20, HSIZE_WORD, 32'h0, cyc, rdy, rsp, rd);
        ex = exp_q.pop_front();
        total++; if (rd !== ex) begin bad++; $display("FAIL byte_write: got %h want %h", rd, ex); end
        do_xfer(1'b1, 32'h22, HSIZE_HALF, 32'h55660000, cyc, rdy, rsp, rd);
        ref_write(1, 32'h22, HSIZE_HALF, 32'h55660000);
        exp_q.push_back(ref_mem[1][8]);
        do_xfer(1'b0, 32'h20, HSIZE_WORD, 32'h0, cyc, rdy, rsp, rd);
        ex = exp_q.pop_front();
        total++; if (rd !== ex) begin bad++; $display("FAIL half_write: got %h want %h", rd, ex); end
    endtask

    task automatic test_errors();
        int          cyc;
        logic [31:0] rdy, rsp, rd, ex;
        sel = 1;
        do_xfer(1'b1, 32'h00, HSIZE_WORD, 32'h12345678, cyc, rdy, rsp, rd);
        ref_write(1, 32'h00, HSIZE_WORD, 32'h12345678);
        do_xfer(1'b1, 32'h01, HSIZE_HALF, 32'hFFFFFFFF, cyc, rdy, rsp, rd);
        total++; if (cyc !== 2 || rdy[1:0] !== 2'b10 || rsp[1:0] !== 2'b11) begin bad++; $display("FAIL err_half: got cycles=%0d rdy=%b resp=%b want 2 / 10 / 11", cyc, rdy[1:0], rsp[1:0]); end
        do_xfer(1'b1, 32'h00, 3'd3, 32'hFFFFFFFF, cyc, rdy, rsp, rd);
        total++; if (cyc !== 2 || rdy[1:0] !== 2'b10 || rsp[1:0] !== 2'b11) begin bad++; $display("FAIL err_size3: got cycles=%0d rdy=%b resp=%b want 2 / 10 / 11", cyc, rdy[1:0], rsp[1:0]); end
        exp_q.push_back(ref_mem[1][0]);
        do_xfer(1'b0, 32'h00, HSIZE_WORD, 32'h0, cyc, rdy, rsp, rd);
        ex = exp_q.pop_front();
        total++; if (rd !== ex || rsp[1:0] !== 2'b00) begin bad++; $display("FAIL err_no_write: got %h resp=%b want %h / 00", rd, rsp[1:0], ex); end
    endtask

    task automatic test_video();
        int          cyc;
        logic [31:0] rdy, rsp, rd, ex;
        sel = 0;
        do_xfer(1'b1, 32'h14, HSIZE_WORD, 32'hCAFEF00D, cyc, rdy, rsp, rd);
        ref_write(0, 32'h14, HSIZE_WORD, 32'hCAFEF00D);
        do_xfer(1'b1, 32'h18, HSIZE_WORD, 32'h11111111, cyc, rdy, rsp, rd);
        ref_write(0, 32'h18, HSIZE_WORD, 32'h11111111);
        @(negedge clk);
        vid_addr = 10'd5;
        exp_q.push_back(ref_mem[0][5]);
        @(negedge clk);
        ex = exp_q.pop_front();
        total++; if (vid_rdata0 !== ex) begin bad++; $display("FAIL vid_read: got %h want %h", vid_rdata0, ex); end
        drive_addr(1'b1, 32'h18, HSIZE_WORD);
        @(negedge clk);
        drive_idle();
        hwdata   = 32'h22222222;
        vid_addr = 10'd6;
        exp_q.push_back(ref_mem[0][6]);
        ref_write(0, 32'h18, HSIZE_WORD, 32'h22222222);
        exp_q.push_back(ref_mem[0][6]);
        @(negedge clk);
        ex = exp_q.pop_front();
        total++; if (vid_rdata0 !== ex) begin bad++; $display("FAIL vid_collision_old: got %h want %h", vid_rdata0, ex); end
        @(negedge clk);
        ex = exp_q.pop_front();
        total++; if (vid_rdata0 !== ex) begin bad++; $display("FAIL vid_after_write: got %h want %h", vid_rdata0, ex); end
    endtask

    task automatic test_reset_mid();
        int          cyc;
        logic [31:0] rdy, rsp, rd, ex;
        sel = 1;
        do_xfer(1'b1, 32'h30, HSIZE_WORD, 32'h0BADF00D, cyc, rdy, rsp, rd);
        ref_write(1, 32'h30, HSIZE_WORD, 32'h0BADF00D);
        exp_q.push_back(ref_mem[1][12]);
        do_xfer(1'b0, 32'h30, HSIZE_WORD, 32'h0, cyc, rdy, rsp, rd);
        ex = exp_q.pop_front();
        total++; if (rd !== ex) begin bad++; $display("FAIL pre_reset_read: got %h want %h", rd, ex); end
        @(negedge clk);
        drive_addr(1'b1, 32'h30, HSIZE_WORD);
        @(negedge clk);
        drive_idle();
        hwdata = 32'hFFFFFFFF;
        total++; if (hreadyout_m !== 1'b0) begin bad++; $display("FAIL mid_wait: got rdy=%b want 0", hreadyout_m); end
        hreset = 1'b1;
        #1;
        total++; if (hreadyout_m !== 1'b1 || hresp_m !== 1'b0 || hrdata_m !== 32'h0) begin bad++; $display("FAIL mid_reset_outputs: got rdy=%b resp=%b data=%h want 1 / 0 / 0", hreadyout_m, hresp_m, hrdata_m); end
        @(negedge clk);
        hreset = 1'b0;
        exp_q.push_back(ref_mem[1][12]);
        do_xfer(1'b0, 32'h30, HSIZE_WORD, 32'h0, cyc, rdy, rsp, rd);
        ex = exp_q.pop_front();
        total++; if (rd !== ex) begin bad++; $display("FAIL write_dropped: got %h want %h", rd, ex); end
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        sel      = 1;
        hreset   = 1'b1;
        haddr    = '0;
        hsize    = HSIZE_WORD;
        hwdata   = '0;
        vid_addr = '0;
        drive_idle();
        test_reset();
        test_wait_states();
        test_back_to_back();
        test_byte_lanes();
        test_errors();
        test_video();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
